// File: rtl/acq_sequencer.sv
// acq_sequencer: clears the datapath, waits for it to become ready, drops pre_skip samples,
// then forwards n_samples registered samples and reports completion or a ready timeout.
module acq_sequencer #(
  parameter int DATA_W         = 32,
  parameter int CLR_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       n_samples,
  input  logic [15:0]       pre_skip,
  input  logic              ready_to_calculate,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              proc_clear,
  output logic              proc_enable,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              calculo_finalizado,
  output logic              timeout_err,
  output logic [31:0]       sample_count
);
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_READY, SKIP, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [31:0] n_lat, cyc, cnt_inc;
  logic [15:0] skip_lat, skip_cnt;
  logic accept, cap, last, clr_done, expired;
  always_comb begin
    accept = (state == IDLE || state == DONE) && start && !abort && n_samples != 32'd0;
    cap = state == CAPTURE && data_in_valid && !abort;
    cnt_inc = &sample_count ? sample_count : sample_count + 32'd1;
    last = cap && cnt_inc == n_lat;
    clr_done = cyc == 32'(CLR_CYCLES - 1);
    expired = state == WAIT_READY && !ready_to_calculate && cyc == 32'(TIMEOUT_CYCLES - 1);
    nxt = state;
    case (state)
      IDLE, DONE: nxt = accept ? CLEAR : state;
      CLEAR:      nxt = clr_done ? WAIT_READY : CLEAR;
      WAIT_READY: nxt = ready_to_calculate ? (skip_lat != 16'd0 ? SKIP : CAPTURE) : (expired ? IDLE : WAIT_READY);
      SKIP:       nxt = data_in_valid && skip_cnt == skip_lat - 16'd1 ? CAPTURE : SKIP;
      CAPTURE:    nxt = last ? DONE : CAPTURE;
      default:    nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
    proc_clear = state == CLEAR;
    proc_enable = state == WAIT_READY || state == SKIP || state == CAPTURE;
    busy = !(state == IDLE || state == DONE);
    calculo_finalizado = state == DONE;
  end
  // cyc restarts on every state change, so it times both CLEAR and WAIT_READY
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      n_lat <= '0;
      skip_lat <= '0;
      skip_cnt <= '0;
      cyc <= '0;
      data_out <= '0;
      data_out_valid <= 1'b0;
      timeout_err <= 1'b0;
      sample_count <= '0;
    end else begin
      state <= nxt;
      cyc <= nxt == state ? cyc + 32'd1 : '0;
      data_out_valid <= cap;
      if (cap) begin
        data_out <= data_in;
        sample_count <= cnt_inc;
      end
      if (state == SKIP && data_in_valid) skip_cnt <= skip_cnt + 16'd1;
      if (expired && !abort) timeout_err <= 1'b1;
      if (accept) begin
        n_lat <= n_samples;
        skip_lat <= pre_skip;
        skip_cnt <= '0;
        sample_count <= '0;
        timeout_err <= 1'b0;
      end
    end
endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, sample width.
REQ-002 The block SHALL have parameter CLR_CYCLES, default 4, length of the datapath clear pulse in clocks (minimum 1).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum clocks to wait for ready_to_calculate.
REQ-004 The block SHALL use a single clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle capture request.
- abort  in  1  single-cycle cancel request.
- n_samples  in  32  samples to capture, latched at accepted start.
- pre_skip  in  16  valid samples to discard before capture, latched at accepted start.
- ready_to_calculate  in  1  datapath ready.
- data_in  in  DATA_W  processed sample.
- data_in_valid  in  1  sample strobe.
- proc_clear  out  1  datapath clear, active-high.
- proc_enable  out  1  datapath enable.
- data_out  out  DATA_W  captured sample to result FIFO.
- data_out_valid  out  1  captured sample strobe.
- busy  out  1  high in every state except IDLE and DONE.
- calculo_finalizado  out  1  capture complete.
- timeout_err  out  1  sticky ready timeout flag.
- sample_count  out  32  samples forwarded in the current or last capture.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, CLEAR, WAIT_READY, SKIP, CAPTURE and DONE.
REQ-006 In IDLE or DONE, start with n_samples != 0 and abort low SHALL do all of the following:
- latch n_samples and pre_skip;
- clear sample_count, timeout_err and calculo_finalizado;
- enter CLEAR.
REQ-007 A start with n_samples == 0 SHALL be ignored, with no state or output change.
REQ-008 A start received in any busy state SHALL be ignored.
REQ-009 CLEAR SHALL:
- assert proc_clear for exactly CLR_CYCLES clocks;
- keep proc_enable low;
- then enter WAIT_READY.
REQ-010 In WAIT_READY, proc_enable SHALL be high and a cycle counter SHALL run.
REQ-011 In WAIT_READY, ready_to_calculate high SHALL cause entry to SKIP if the latched pre_skip != 0, otherwise to CAPTURE.
REQ-012 When the WAIT_READY counter reaches TIMEOUT_CYCLES with ready_to_calculate still low, the block SHALL set timeout_err, drop proc_enable and return to IDLE.
REQ-013 SKIP SHALL:
- keep proc_enable high;
- discard valid samples without asserting data_out_valid;
- enter CAPTURE on the cycle the pre_skip-th valid sample is consumed.
REQ-014 In CAPTURE, each data_in_valid SHALL produce data_out = data_in and data_out_valid = 1 exactly one clock later (registered), and increment sample_count.
REQ-015 In CAPTURE, data_out_valid SHALL never assert without a corresponding input strobe.
REQ-016 When the sample that makes sample_count equal the latched n_samples is forwarded, the block SHALL:
- enter DONE on the next edge;
- drop proc_enable;
- raise calculo_finalizado.
REQ-017 Valid samples arriving in DONE or IDLE SHALL be discarded.
REQ-018 calculo_finalizado SHALL remain high in DONE until the next accepted start or an abort.
REQ-019 abort SHALL return the FSM to IDLE on the next edge from any state.
REQ-020 On abort, the block SHALL:
- deassert proc_enable and proc_clear;
- suppress any data_out_valid not yet issued;
- keep sample_count at its value;
- clear calculo_finalizado.
REQ-021 When start and abort occur in the same cycle, abort SHALL win.
REQ-022 ready_to_calculate falling during SKIP or CAPTURE SHALL NOT change state; samples are counted purely by data_in_valid.
REQ-023 sample_count SHALL saturate at 2^32-1.

Reset
REQ-024 Asserting reset SHALL place the FSM in IDLE and zero all outputs, data_out and internal counters.
REQ-025 Reset SHALL take effect asynchronously and override all other inputs, including in mid-capture.
REQ-026 Reset release SHALL be consumed synchronously; the first accepted start SHALL be no earlier than the first edge after release.

Verification
REQ-027 Nominal scenario: n_samples=8, pre_skip=0, ready_to_calculate tied high, continuous valid with data_in=k.
- Required: proc_clear high 4 clocks, then exactly 8 data_out_valid with values matching the inputs, 1-clock latency.
- Required: calculo_finalizado high, sample_count=8.
REQ-028 Skip scenario: n_samples=4, pre_skip=3, valid on alternate cycles with data_in=0..9.
- Required: outputs exactly 3,4,5,6, then DONE.
REQ-029 Timeout scenario: TIMEOUT_CYCLES=16, ready_to_calculate held low.
- Required: timeout_err=1 after 16 WAIT_READY clocks, FSM in IDLE, no data_out_valid.
REQ-030 Abort scenario: abort on the cycle after the 5th forwarded sample of n_samples=10.
- Required: IDLE next edge, sample_count=5, calculo_finalizado stays 0, proc_enable=0.
REQ-031 Ignored-start scenario:
- start with n_samples=0 -> no state change;
- start during CAPTURE -> ignored;
- simultaneous start+abort in DONE -> IDLE with calculo_finalizado cleared.
REQ-032 Reset scenario: reset asserted mid-CAPTURE between clock edges -> all outputs 0 immediately, FSM in IDLE after release.
